// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end for one shared combinational adder.
// Two requesters offer operand pairs with valid/ready. The winner's operands
// are latched, summed by the shared adder on the next cycle, and the result
// is held on the output port until the consumer takes it.
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/_a/_b/_ready      requester N operand handshake (N = 0,1)
//   out_valid/_sum/_id/_ready    registered result handshake; carry in MSB
//   busy                         high whenever not IDLE
//   txn_count                    completed result handshakes, wraps

module adder4 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sout
);
  // Zero-extend both operands so the carry-out lands in bit WIDTH.
  assign sout = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH:0]   out_sum,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id;
  } opnd_t;

  state_t           state;
  logic             last_grant;
  opnd_t            op;
  logic             grant0, grant1;
  logic [WIDTH:0]   sum;

  // Round-robin: under contention the requester that did not win last time
  // gets the grant. last_grant resets to 1 so req0 wins first.
  assign grant0     = req0_valid & (~req1_valid | last_grant);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign busy       = (state != IDLE);

  // The adder only ever sees registered operands.
  adder4 #(.WIDTH(WIDTH)) u_add (
    .a    (op.a),
    .b    (op.b),
    .sout (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op         <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_id     <= 1'b0;
      txn_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op         <= '{a: req0_a, b: req0_b, id: 1'b0};
            last_grant <= 1'b0;
            state      <= CALC;
          end else if (req1_ready) begin
            op         <= '{a: req1_a, b: req1_b, id: 1'b1};
            last_grant <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          out_sum   <= sum;
          out_id    <= op.id;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational 64-bit adder between two requesters: `adder4`, with ports a[63:0], b[63:0] and sout[64:0].
- Arbitration is round-robin. Each requester port and the result port use valid/ready handshakes.
- One transaction is in flight at a time. Operands and result are both registered, so the adder output is never exposed combinationally.
- Sits between the operand-producing logic and the adder. Within the summation datapath it is the single point of access to the adder.

Parameters:
- WIDTH, 64: operand width. Result is WIDTH+1 bits and carries the carry-out in bit WIDTH.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has operands.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req1_valid  input  1  requester 1 has operands.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- out_valid  output  1  result available.
- out_sum  output  WIDTH+1  registered sum, carry in MSB.
- out_id  output  1  index of the requester that owns out_sum.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in any state other than IDLE.
- txn_count  output  CNT_W  number of completed result handshakes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1, out_valid=0, out_sum=0, out_id=0, txn_count=0.
  - Operand registers are cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE, grant logic (combinational):
  - grant0 = req0_valid & (~req1_valid | last_grant==1).
  - grant1 = req1_valid & (~req0_valid | last_grant==0).
  - reqN_ready = (state==IDLE) & grantN. Ready is never high in CALC or DONE, and never high without valid.
- IDLE, on accept (valid&ready):
  - Latch a, b and id into the operand registers.
  - last_grant <= granted id.
  - Go to CALC.
- IDLE with no valid: stay in IDLE.
- CALC:
  - out_sum <= adder sout (zero-extended WIDTH+1 sum of the latched operands).
  - out_id <= latched id, out_valid <= 1.
  - Go to DONE.
- DONE:
  - out_valid=1; out_sum and out_id are held stable until the handshake.
  - On out_ready: out_valid <= 0, txn_count += 1 (wraps modulo 2^CNT_W), go to IDLE.
  - Without out_ready: hold indefinitely (backpressure).
- Latency: accept at edge N gives out_valid=1 after edge N+1. With out_ready held at 1, the next accept can occur at edge N+3. Maximum throughput is one transaction per 3 cycles.
- Fairness:
  - When both requesters are valid continuously, grants alternate 0,1,0,1…, and the first grant after reset goes to req0.
  - A lone requester is granted every time it is valid in IDLE.
- Arithmetic: unsigned, no overflow loss. 2^64-1 + 2^64-1 = 65'h1_FFFF_FFFF_FFFF_FFFE.
- Requester operands may change freely while reqN_ready=0. Only values present at the accept edge are used.
- Reset mid-operation (in CALC or DONE): the transaction is discarded with no output handshake, and all registers return to their reset values on that edge.

Test Plan:
1. Single request: req0 a=18446744073709551614, b=1 → req0_ready high in the same cycle; out_valid 2 edges later; out_sum=18446744073709551615, out_id=0, carry bit=0.
2. Carry-out: req1 a=2^64-1, b=1 → out_sum=65'h1_0000_0000_0000_0000, out_id=1. A second case, a=8446744073709551614 and b=10000000000000000000, gives out_sum=18446744073709551614.
3. Contention: both requesters valid continuously; req0 (184+1256) and req1 (156596564+125556); out_ready=1 → results in order 1440 (id 0), 156722120 (id 1), 1440 (id 0); one accept every 3 cycles; txn_count=3.
4. Backpressure: req0 14+7, out_ready=0 for 5 cycles → out_valid held, out_sum=21 stable, both readys 0, busy=1. Raise out_ready → one handshake, txn_count increments once, return to IDLE.
5. Reset in DONE: assert rst while out_valid=1 → next cycle out_valid=0, out_sum=0, txn_count=0, state IDLE. The next simultaneous request is granted to req0.
6. Operand change while not ready: req1 changes a/b during CALC/DONE of a req0 transaction → req1's result uses only the values present at its accept edge.
